inst_fifo: RTL and testbench

//  Dual-issue instruction queue between fetch and the two execution pipelines.

---
 rtl/common_pkg.sv | 14 +
 rtl/inst_fifo_ram.sv | 35 +++
 rtl/inst_fifo.sv | 143 ++++++++++++++
 tb/tb_inst_fifo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the instruction queue: one entry is a {pc, instruction} pair.
package common_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] inst;
  } inst_fifo_entry_t;

  // An all-zero word decodes as sll $0,$0,0, so an idle slot is a harmless nop.
  localparam logic [31:0] INST_NOP = 32'd0;

  localparam inst_fifo_entry_t ENTRY_NOP = '{address: 32'd0, inst: INST_NOP};

endpackage

// File: rtl/inst_fifo_ram.sv
// Entry storage for inst_fifo: two write ports (tail, tail+1) and two
// asynchronous read ports (head, head+1).
module inst_fifo_ram
  import common_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we1,
  input  logic             i_we2,
  input  logic [ADDR_W-1:0] i_waddr1,
  input  logic [ADDR_W-1:0] i_waddr2,
  input  inst_fifo_entry_t i_wdata1,
  input  inst_fifo_entry_t i_wdata2,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output inst_fifo_entry_t o_rdata1,
  output inst_fifo_entry_t o_rdata2
);

  inst_fifo_entry_t r_mem [DEPTH];

  // Store up to two entries per cycle; the two addresses are always distinct.
  // NOTE: storage has no reset; validity comes from the top-level count, so
  // clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    if (i_we2) r_mem[i_waddr2] <= i_wdata2;
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and the master/slave pipelines.
// Optional feature: define INST_FIFO_BYPASS_EN to let pushes into a nearly
// empty queue appear on the read slots in the same cycle.
module inst_fifo
  import common_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_address1,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_address2,
  input  logic [31:0] write_inst2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_address1,
  output logic [31:0] read_inst1,
  output logic        read_valid1,
  output logic [31:0] read_address2,
  output logic [31:0] read_inst2,
  output logic        read_valid2,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
);

  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;

  logic              w_empty;
  logic              w_almost_empty;
  logic              w_full;
  logic              w_push_ok;
  logic [1:0]        w_push_n;
  logic [1:0]        w_req_n;
  logic [1:0]        w_avail_n;
  logic [1:0]        w_pop_n;
  inst_fifo_entry_t  w_wr1;
  inst_fifo_entry_t  w_wr2;
  inst_fifo_entry_t  w_ram1;
  inst_fifo_entry_t  w_ram2;
  inst_fifo_entry_t  w_slot1;
  inst_fifo_entry_t  w_slot2;
  logic              w_valid1;
  logic              w_valid2;

  assign w_empty        = (r_count == '0);
  assign w_almost_empty = (r_count == (ADDR_W+1)'(1));
  assign w_full         = (r_count >= (ADDR_W+1)'(DEPTH - 1));

  // A push is all-or-nothing: dropped entirely when full, flushing or in reset.
  assign w_push_ok = write_en1 & ~flush & ~rst & ~w_full;
  assign w_push_n  = w_push_ok ? (write_en2 ? 2'd2 : 2'd1) : 2'd0;

  assign w_wr1 = '{address: write_address1, inst: write_inst1};
  assign w_wr2 = '{address: write_address2, inst: write_inst2};

  inst_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .i_we1    (w_push_ok),
    .i_we2    (w_push_ok & write_en2),
    .i_waddr1 (r_tail),
    .i_waddr2 (r_tail + ADDR_W'(1)),
    .i_wdata1 (w_wr1),
    .i_wdata2 (w_wr2),
    .i_raddr1 (r_head),
    .i_raddr2 (r_head + ADDR_W'(1)),
    .o_rdata1 (w_ram1),
    .o_rdata2 (w_ram2)
  );

  // Select what each read slot shows and mask slots that hold no real entry.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_slot1  = ENTRY_NOP;
    w_slot2  = ENTRY_NOP;
    w_valid1 = 1'b0;
    w_valid2 = 1'b0;
    if (r_count >= (ADDR_W+1)'(1)) begin
      w_slot1  = w_ram1;
      w_valid1 = 1'b1;
    end
    if (r_count >= (ADDR_W+1)'(2)) begin
      w_slot2  = w_ram2;
      w_valid2 = 1'b1;
    end
`ifdef INST_FIFO_BYPASS_EN
    if (w_push_ok) begin
      if (w_empty) begin
        w_slot1  = w_wr1;
        w_valid1 = 1'b1;
        if (write_en2) begin
          w_slot2  = w_wr2;
          w_valid2 = 1'b1;
        end
      end else if (w_almost_empty) begin
        w_slot2  = w_wr1;
        w_valid2 = 1'b1;
      end
    end
`endif
  end

  // Pops are limited to slots actually showing a real entry, so count never
  // underflows. Bypassed entries are written and skipped in the same cycle,
  // which leaves exactly the unconsumed remainder in order.
  assign w_req_n   = read_en1 ? (read_en2 ? 2'd2 : 2'd1) : 2'd0;
  assign w_avail_n = {1'b0, w_valid1} + {1'b0, w_valid2};
  assign w_pop_n   = (w_req_n < w_avail_n) ? w_req_n : w_avail_n;

  // Pointer and occupancy update; flush and reset both empty the queue.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + ADDR_W'(w_pop_n);
      r_tail  <= r_tail + ADDR_W'(w_push_n);
      r_count <= r_count + (ADDR_W+1)'(w_push_n) - (ADDR_W+1)'(w_pop_n);
    end
  end

  assign read_address1 = w_slot1.address;
  assign read_inst1    = w_slot1.inst;
  assign read_valid1   = w_valid1;
  assign read_address2 = w_slot2.address;
  assign read_inst2    = w_slot2.inst;
  assign read_valid2   = w_valid2;
  assign empty         = w_empty;
  assign almost_empty  = w_almost_empty;
  assign full          = w_full;

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: a queue-based model compared on every
// falling edge, plus hand-computed expectations for the directed scenarios.
// Honours INST_FIFO_BYPASS_EN the same way the design does.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_address1, write_inst1, write_address2, write_inst2;
  logic [31:0] read_address1, read_inst1, read_address2, read_inst2;
  logic        read_valid1, read_valid2, empty, almost_empty, full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .write_en1      (write_en1),
    .write_en2      (write_en2),
    .write_address1 (write_address1),
    .write_inst1    (write_inst1),
    .write_address2 (write_address2),
    .write_inst2    (write_inst2),
    .read_en1       (read_en1),
    .read_en2       (read_en2),
    .read_address1  (read_address1),
    .read_inst1     (read_inst1),
    .read_valid1    (read_valid1),
    .read_address2  (read_address2),
    .read_inst2     (read_inst2),
    .read_valid2    (read_valid2),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .full           (full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a queue of {pc, inst} ----------------
  logic [63:0] mq[$];
  bit          model_ok = 1'b0;
  int          m_nv, m_req, m_pop;
  logic [63:0] m_e1, m_e2;

  function automatic bit push_ok();
    return write_en1 && !flush && !rst && (mq.size() < DEPTH - 1);
  endfunction

  function automatic int n_pushes();
    return push_ok() ? (write_en2 ? 2 : 1) : 0;
  endfunction

  // Entries visible to the read slots this cycle, oldest first.
  function automatic int n_visible();
    int n = mq.size();
`ifdef INST_FIFO_BYPASS_EN
    n += n_pushes();
`endif
    return (n > 2) ? 2 : n;
  endfunction

  function automatic logic [63:0] visible(input int k);
    int n = mq.size();
    if (k < n) return mq[k];
`ifdef INST_FIFO_BYPASS_EN
    if (push_ok() && k == n) return {write_address1, write_inst1};
    if (push_ok() && write_en2 && k == n + 1) return {write_address2, write_inst2};
`endif
    return 64'd0;
  endfunction

  // Advance the model on each rising edge using the inputs held that cycle.
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      if (rst) model_ok = 1'b1;
    end else begin
      m_nv  = n_visible();
      m_req = read_en1 ? (read_en2 ? 2 : 1) : 0;
      m_pop = (m_req < m_nv) ? m_req : m_nv;
      if (push_ok()) begin
        mq.push_back({write_address1, write_inst1});
        if (write_en2) mq.push_back({write_address2, write_inst2});
      end
      for (int i = 0; i < m_pop; i++) void'(mq.pop_front());
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      m_nv = n_visible();
      m_e1 = visible(0);
      m_e2 = visible(1);
      check("m_valid1",   32'(read_valid1),   32'(m_nv >= 1));
      check("m_valid2",   32'(read_valid2),   32'(m_nv >= 2));
      check("m_address1", read_address1,      m_e1[63:32]);
      check("m_inst1",    read_inst1,         m_e1[31:0]);
      check("m_address2", read_address2,      m_e2[63:32]);
      check("m_inst2",    read_inst2,         m_e2[31:0]);
      check("m_empty",    32'(empty),         32'(mq.size() == 0));
      check("m_almost",   32'(almost_empty),  32'(mq.size() == 1));
      check("m_full",     32'(full),          32'(mq.size() >= DEPTH - 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] addr(input int k);
    return 32'h1000_0000 + 32'(k * 4);
  endfunction

  function automatic logic [31:0] ins(input int k);
    return 32'hA000_0000 + 32'(k);
  endfunction

  task automatic idle();
    flush = 1'b0; write_en1 = 1'b0; write_en2 = 1'b0;
    read_en1 = 1'b0; read_en2 = 1'b0;
    write_address1 = '0; write_inst1 = '0;
    write_address2 = '0; write_inst2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input int k, input bit two);
    write_en1 = 1'b1; write_en2 = two;
    write_address1 = addr(k);     write_inst1 = ins(k);
    write_address2 = addr(k + 1); write_inst2 = ins(k + 1);
  endtask

  task automatic pop(input bit two);
    read_en1 = 1'b1; read_en2 = two;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_empty",  32'(empty),        32'd1);
    check("rst_full",   32'(full),         32'd0);
    check("rst_almost", 32'(almost_empty), 32'd0);
    check("rst_valid1", 32'(read_valid1),  32'd0);
    check("rst_valid2", 32'(read_valid2),  32'd0);
    check("rst_addr1",  read_address1,     32'd0);
    check("rst_inst2",  read_inst2,        32'd0);

    // Two-entry push becomes visible next cycle.
    write_en1 = 1'b1; write_en2 = 1'b1;
    write_address1 = 32'hBFC0_0000; write_inst1 = 32'h2401_0001;
    write_address2 = 32'hBFC0_0004; write_inst2 = 32'h2402_0002;
    tick();
    check("t1_valid1", 32'(read_valid1), 32'd1);
    check("t1_valid2", 32'(read_valid2), 32'd1);
    check("t1_addr1",  read_address1,    32'hBFC0_0000);
    check("t1_inst2",  read_inst2,       32'h2402_0002);
    check("t1_empty",  32'(empty),       32'd0);

    // Fill to 15 entries, then a push must be dropped.
    do_reset();
    push(0, 1'b0); tick();
    for (int i = 0; i < 7; i++) begin
      push(1 + 2 * i, 1'b1); tick();
    end
    check("t2_full15",   32'(full), 32'd1);
    push(20, 1'b1); tick();
    check("t2_full_hold", 32'(full), 32'd1);
    pop(1'b0); tick();
    check("t2_full_drop", 32'(full),     32'd0);
    check("t2_addr1",     read_address1, addr(1));
    check("t2_addr2",     read_address2, addr(2));

    // Double read with one entry: only one pop, slot 2 stays a nop.
    do_reset();
    push(30, 1'b0); tick();
    check("t3_almost", 32'(almost_empty), 32'd1);
    pop(1'b1);
    #1;
    check("t3_valid1_now", 32'(read_valid1), 32'd1);
    check("t3_valid2_now", 32'(read_valid2), 32'd0);
    check("t3_inst2_now",  read_inst2,       32'd0);
    tick();
    check("t3_empty",  32'(empty),       32'd1);
    check("t3_valid1", 32'(read_valid1), 32'd0);
    check("t3_inst2",  read_inst2,       32'd0);

    // Move head to index 14, then push 2 + pop 2 across the wrap.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push(40 + 2 * i, 1'b1); tick();
    end
    for (int i = 0; i < 7; i++) begin
      pop(1'b1); tick();
    end
    check("t4_drained", 32'(empty), 32'd1);
    push(60, 1'b1); tick();
    push(62, 1'b1); pop(1'b1); tick();
    check("t4_valid2", 32'(read_valid2),  32'd1);
    check("t4_almost", 32'(almost_empty), 32'd0);
    check("t4_addr1",  read_address1,     32'h1000_00F8);
    check("t4_addr2",  read_address2,     32'h1000_00FC);

    // Flush at count 9 discards the queue and the same-cycle write.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(70 + 2 * i, 1'b1); tick();
    end
    push(78, 1'b0); tick();
    check("t5_not_full", 32'(full), 32'd0);
    flush = 1'b1; push(90, 1'b0); pop(1'b1); tick();
    check("t5_empty",  32'(empty),       32'd1);
    check("t5_valid1", 32'(read_valid1), 32'd0);
    check("t5_valid2", 32'(read_valid2), 32'd0);
    check("t5_addr1",  read_address1,    32'd0);
    check("t5_inst1",  read_inst1,       32'd0);
    tick();
    check("t5_still_empty", 32'(empty), 32'd1);

    // Push into an empty queue while reading slot 1.
    do_reset();
    write_en1 = 1'b1;
    write_address1 = 32'h8000_0010; write_inst1 = 32'h0022_1820;
    read_en1 = 1'b1;
    #1;
`ifdef INST_FIFO_BYPASS_EN
    check("t6_valid1_now", 32'(read_valid1), 32'd1);
    check("t6_inst1_now",  read_inst1,       32'h0022_1820);
    tick();
    check("t6_empty", 32'(empty), 32'd1);
`else
    check("t6_valid1_now", 32'(read_valid1), 32'd0);
    check("t6_inst1_now",  read_inst1,       32'd0);
    tick();
    check("t6_almost", 32'(almost_empty), 32'd1);
    check("t6_inst1",  read_inst1,        32'h0022_1820);
`endif

    // Mixed traffic for the model: odd/even pushes with random reads.
    for (int i = 0; i < 40; i++) begin
      if (i % 3 != 2) push(100 + 2 * i, (i % 2) == 0);
      if (i % 4 != 0) pop($urandom_range(0, 1) == 1);
      tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
